// File: rtl/spi_master_transmitter_pkg.sv
// Shared types and mode-0 bus constants for the SPI master transmitter.
//   spi_state_t : transmitter FSM states
//   SCLK_IDLE   : SCLK level between transfers (mode 0 idles low)
//   CS_INACTIVE : chip-select level when no frame is open
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    GAP,
    TRAIL
  } spi_state_t;

  localparam logic SCLK_IDLE   = 1'b0;
  localparam logic CS_INACTIVE = 1'b1;

endpackage

// File: rtl/spi_master_transmitter_clk_divider.sv
// SCLK half-period divider. Counts 0..CLK_DIV-1 while enabled and flags the
// wrap cycle as a tick; every SCLK edge and phase boundary lands on a tick.
//   clk, rst_n : system clock, asynchronous active-low reset
//   enable     : count while high
//   clear      : force the count back to 0 (takes priority over enable)
//   tick       : high on the cycle the count wraps
module spi_clk_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/spi_master_transmitter.sv
// Mode-0, MSB-first SPI master. Words arrive on a valid/ready stream into a
// one-entry holding register; back-to-back words share one CS_N frame with a
// single dummy SCLK period (MOSI at IDLE_VAL) between them.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   data_in             : word to transmit
//   data_in_valid/ready : stream handshake (ready = hold register empty)
//   abort               : synchronous kill of the current transfer and hold
//   sclk, cs_n, mosi    : registered SPI bus outputs
//   busy                : FSM is outside IDLE
module spi_master_transmitter
  import spi_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   CLK_DIV    = 2,
  parameter logic IDLE_VAL   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  input  logic                  abort,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  output logic                  busy
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_WIDTH);

  spi_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_valid_q;
  logic                  hold_take;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic                  tick;
  logic                  handshake;

  assign data_in_ready = !hold_valid_q;
  assign handshake     = data_in_valid && data_in_ready;
  assign busy          = (state_q != IDLE);
  assign sclk          = sclk_q;
  assign cs_n          = cs_n_q;
  assign mosi          = mosi_q;

  // The divider is held at zero in IDLE so LEAD always gets a full half-period.
  spi_clk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_q != IDLE),
    .clear  (state_q == IDLE),
    .tick   (tick)
  );

  // Holding register: abort flushes it and swallows a same-cycle handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
    end else if (abort) begin
      hold_valid_q <= 1'b0;
    end else if (handshake) begin
      hold_valid_q <= 1'b1;
    end else if (hold_take) begin
      hold_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (handshake && !abort) begin
      hold_q <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sclk_q    <= SCLK_IDLE;
      cs_n_q    <= CS_INACTIVE;
      mosi_q    <= IDLE_VAL;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
    end
  end

  // Bus outputs are computed alongside the next state so they change on the
  // same edge as the state they belong to.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    hold_take = 1'b0;

    if (abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sclk_d    = SCLK_IDLE;
      cs_n_d    = CS_INACTIVE;
      mosi_d    = IDLE_VAL;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          sclk_d    = SCLK_IDLE;
          cs_n_d    = CS_INACTIVE;
          mosi_d    = IDLE_VAL;
          if (hold_valid_q) begin
            state_d   = LEAD;
            shift_d   = hold_q;
            hold_take = 1'b1;
            cs_n_d    = !CS_INACTIVE;
            mosi_d    = hold_q[DATA_WIDTH-1];
          end
        end

        LEAD: begin
          if (tick) begin
            state_d = SHIFT;
          end
        end

        SHIFT: begin
          if (tick) begin
            if (sclk_q == SCLK_IDLE) begin
              sclk_d    = !SCLK_IDLE;
              bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
              sclk_d = SCLK_IDLE;
              // The falling edge after the last rise closes the word.
              if (bit_cnt_q == BITS_LAST) begin
                bit_cnt_d = '0;
                mosi_d    = IDLE_VAL;
                state_d   = hold_valid_q ? GAP : TRAIL;
              end else begin
                shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                mosi_d  = shift_q[DATA_WIDTH-2];
              end
            end
          end
        end

        GAP: begin
          // Dummy SCLK period; the next word is loaded on its falling edge.
          if (tick) begin
            if (sclk_q == SCLK_IDLE) begin
              sclk_d = !SCLK_IDLE;
            end else begin
              sclk_d    = SCLK_IDLE;
              state_d   = SHIFT;
              shift_d   = hold_q;
              hold_take = 1'b1;
              mosi_d    = hold_q[DATA_WIDTH-1];
            end
          end
        end

        TRAIL: begin
          if (tick) begin
            state_d = IDLE;
            cs_n_d  = CS_INACTIVE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_transmitter.sv
module tb_spi_master_transmitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_in_valid, data_in_ready, abort;
  logic       sclk, cs_n, mosi, busy;

  logic [7:0] d1_data;
  logic       d1_valid, d1_ready, d1_abort;
  logic       d1_sclk, d1_cs_n, d1_mosi, d1_busy;

  always #5 clk = ~clk;

  spi_master_transmitter #(
    .DATA_WIDTH (8),
    .CLK_DIV    (2),
    .IDLE_VAL   (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .abort         (abort),
    .sclk          (sclk),
    .cs_n          (cs_n),
    .mosi          (mosi),
    .busy          (busy)
  );

  spi_master_transmitter #(
    .DATA_WIDTH (8),
    .CLK_DIV    (1),
    .IDLE_VAL   (1'b1)
  ) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (d1_data),
    .data_in_valid (d1_valid),
    .data_in_ready (d1_ready),
    .abort         (d1_abort),
    .sclk          (d1_sclk),
    .cs_n          (d1_cs_n),
    .mosi          (d1_mosi),
    .busy          (d1_busy)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic       rise_bits[$];
  logic       rise1_bits[$];
  int         cs_low, cs_rises, rdy_gap, rdy_other, busy_bad;
  int         cs_low1, rise1_bad, last_rise1, cyc;
  logic       prev_sclk, prev_cs, prev_rdy, prev_sclk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rise_bits.delete();
    rise1_bits.delete();
    cs_low     = 0;
    cs_rises   = 0;
    rdy_gap    = 0;
    rdy_other  = 0;
    busy_bad   = 0;
    cs_low1    = 0;
    rise1_bad  = 0;
    last_rise1 = -1;
    prev_sclk  = sclk;
    prev_cs    = cs_n;
    prev_rdy   = data_in_ready;
    prev_sclk1 = d1_sclk;
  endtask

  // One clock: present the head of tx_q, cross the edge, then sample at +1.
  task automatic step();
    logic hs;
    logic fell;
    if (tx_q.size() != 0) begin
      data_in       = tx_q[0];
      data_in_valid = 1'b1;
    end else begin
      data_in_valid = 1'b0;
    end
    hs = data_in_valid && data_in_ready && !abort;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) void'(tx_q.pop_front());
    if (sclk && !prev_sclk) rise_bits.push_back(mosi);
    fell = !sclk && prev_sclk;
    if (!cs_n) cs_low++;
    if (cs_n && !prev_cs) cs_rises++;
    if (data_in_ready && !prev_rdy) begin
      if (fell) rdy_gap++;
      else rdy_other++;
    end
    if (busy !== !cs_n) busy_bad++;
    prev_sclk = sclk;
    prev_cs   = cs_n;
    prev_rdy  = data_in_ready;
    if (d1_sclk && !prev_sclk1) begin
      rise1_bits.push_back(d1_mosi);
      if (last_rise1 >= 0 && (cyc - last_rise1) != 2) rise1_bad++;
      last_rise1 = cyc;
    end
    if (!d1_cs_n) cs_low1++;
    prev_sclk1 = d1_sclk;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(tx_q.size() == 0 && data_in_ready && !busy) && n < budget);
    chk({tag, "_done"}, (tx_q.size() == 0 && data_in_ready && !busy), 1);
  endtask

  task automatic wait_rises(input string tag, input int nr, input int budget);
    int n = 0;
    while (rise_bits.size() < nr && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_rises_reached"}, rise_bits.size(), nr);
  endtask

  // Slave-side view: 8 data rises per word, one dummy rise between words.
  task automatic check_words(input string tag);
    int nw = 0;
    for (int w = 0; w * 9 + 8 <= rise_bits.size(); w++) begin
      logic [7:0] word = '0;
      for (int b = 0; b < 8; b++) word = {word[6:0], rise_bits[w * 9 + b]};
      if (w < exp_q.size()) chk($sformatf("%s_word%0d", tag, w), word, exp_q[w]);
      if (w * 9 + 8 < rise_bits.size())
        chk($sformatf("%s_dummy%0d", tag, w), rise_bits[w * 9 + 8], 1);
      nw++;
    end
    chk({tag, "_word_count"}, nw, exp_q.size());
  endtask

  initial begin
    rst_n         = 1'b0;
    data_in       = '0;
    data_in_valid = 1'b0;
    abort         = 1'b0;
    d1_data       = '0;
    d1_valid      = 1'b0;
    d1_abort      = 1'b0;
    cyc           = 0;

    // Reset state
    #12;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", data_in_ready, 1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();

    // Single word 0xA5
    tx_q.push_back(8'hA5);
    wait_done("single", 300);
    chk("single_cs_low", cs_low, 36);
    chk("single_cs_frames", cs_rises, 1);
    chk("single_rises", rise_bits.size(), 8);
    chk("single_busy_vs_cs", busy_bad, 0);
    exp_q = {};
    exp_q.push_back(8'hA5);
    check_words("single");
    repeat (3) step();

    // Back-to-back burst with backpressure
    clear_mon();
    tx_q.push_back(8'h12);
    tx_q.push_back(8'h7E);
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hA5);
    step();
    step();
    step();
    chk("bp_two_taken", tx_q.size(), 2);
    chk("bp_ready_low", data_in_ready, 0);
    wait_done("burst", 1000);
    chk("burst_cs_frames", cs_rises, 1);
    chk("burst_cs_low", cs_low, 144);
    chk("burst_rises", rise_bits.size(), 35);
    chk("bp_ready_at_gap_fall", rdy_gap, 3);
    chk("bp_ready_other", rdy_other, 1);
    chk("burst_busy_vs_cs", busy_bad, 0);
    exp_q = {};
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hA5);
    check_words("burst");
    repeat (3) step();

    // Abort after the 4th rise of the third word
    clear_mon();
    tx_q.push_back(8'h12);
    tx_q.push_back(8'h7E);
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hA5);
    wait_rises("abort", 22, 1000);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_mosi", mosi, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", data_in_ready, 1);
    tx_q.delete();
    repeat (10) step();
    chk("abort_no_restart_rises", rise_bits.size(), 22);
    chk("abort_cs_stays_high", cs_n, 1);
    exp_q = {};
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h7E);
    check_words("abort");

    // Asynchronous reset mid-SHIFT
    clear_mon();
    tx_q.push_back(8'hC3);
    wait_rises("rstmid", 3, 300);
    chk("rstmid_pre_cs_n", cs_n, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_cs_n", cs_n, 1);
    chk("rstmid_sclk", sclk, 0);
    chk("rstmid_mosi", mosi, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", data_in_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tx_q.delete();
    clear_mon();
    tx_q.push_back(8'h3C);
    wait_done("after_rst", 300);
    chk("after_rst_cs_low", cs_low, 36);
    chk("after_rst_rises", rise_bits.size(), 8);
    exp_q = {};
    exp_q.push_back(8'h3C);
    check_words("after_rst");

    // CLK_DIV=1 corner with 0xFF
    clear_mon();
    chk("div1_ready_idle", d1_ready, 1);
    d1_data  = 8'hFF;
    d1_valid = 1'b1;
    step();
    d1_valid = 1'b0;
    begin
      int n = 0;
      do begin
        step();
        n++;
      end while (!(d1_ready && !d1_busy) && n < 100);
      chk("div1_done", (d1_ready && !d1_busy), 1);
    end
    chk("div1_cs_low", cs_low1, 18);
    chk("div1_rises", rise1_bits.size(), 8);
    chk("div1_period", rise1_bad, 0);
    begin
      int ones = 0;
      foreach (rise1_bits[i]) if (rise1_bits[i] === 1'b1) ones++;
      chk("div1_mosi_ones", ones, 8);
    end
    chk("div1_cs_n_end", d1_cs_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
